axi_lite_rd_arb: RTL and testbench
==================================

AXI_LITE_RD_ARB -- requirements
Module: axi_lite_rd_arb

Interface
REQ-001 The block SHALL share one AXI-lite read-only slave (info/status register block) between N_REQ AXI-lite read masters; write channels SHALL NOT be part of this block.
REQ-002 Parameter N_REQ, default 2, number of requesters (2..16).
REQ-003 Parameter ADDR_WIDTH, default 8, AXI-lite byte-address width.
REQ-004 Parameter DATA_WIDTH, default 32, AXI-lite data width.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low (ports ap_clk, ap_rst_n).
REQ-006 ap_clk  in  1  clock, all state updates on rising edge.
REQ-007 ap_rst_n  in  1  asynchronous active-low reset.
REQ-008 s_axi_ARVALID  in  N_REQ  per-requester read-address valid.
REQ-009 s_axi_ARREADY  out  N_REQ  per-requester read-address ready.
REQ-010 s_axi_ARADDR  in  N_REQ*ADDR_WIDTH  packed addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 s_axi_RVALID  out  N_REQ  per-requester read-data valid.
REQ-012 s_axi_RREADY  in  N_REQ  per-requester read-data ready.
REQ-013 s_axi_RDATA  out  N_REQ*DATA_WIDTH  packed read data.
REQ-014 s_axi_RRESP  out  2*N_REQ  packed read responses.
REQ-015 m_axi_ARVALID  out  1  slave-side address valid.
REQ-016 m_axi_ARREADY  in  1  slave-side address ready.
REQ-017 m_axi_ARADDR  out  ADDR_WIDTH  slave-side address.
REQ-018 m_axi_RVALID  in  1  slave-side data valid.
REQ-019 m_axi_RREADY  out  1  slave-side data ready.
REQ-020 m_axi_RDATA  in  DATA_WIDTH  slave-side data.
REQ-021 m_axi_RRESP  in  2  slave-side response.

Function
REQ-022 FSM states: IDLE, ADDR, RESP; exactly one transaction outstanding at any time.
REQ-023 IDLE: if any s_axi_ARVALID set, grant index g = first asserted requester searching upward (wrapping) from priority pointer p; s_axi_ARREADY[g]=1 combinationally in that cycle only; register ARADDR[g] and g; go to ADDR.
REQ-024 s_axi_ARREADY SHALL be 0 for all requesters outside IDLE and for all non-granted requesters.
REQ-025 ADDR: m_axi_ARVALID=1 with registered address (asserted first cycle after grant); stable until m_axi_ARREADY; on handshake go to RESP.
REQ-026 RESP: s_axi_RVALID[g]=m_axi_RVALID, m_axi_RREADY=s_axi_RREADY[g], RDATA/RRESP of g = m_axi_RDATA/m_axi_RRESP (combinational pass-through); on m_axi_RVALID&&m_axi_RREADY go to IDLE and set p=(g+1) mod N_REQ.
REQ-027 Non-granted s_axi_RVALID SHALL be 0; their RDATA/RRESP are don't-care.
REQ-028 Minimum latency grant-to-m_axi_ARVALID 1 cycle; back-to-back transactions SHALL have 1 IDLE cycle between RESP handshake and next grant.
REQ-029 Requester deasserting ARVALID while not granted SHALL be legal and ignored; round-robin SHALL guarantee each persistent requester a grant within N_REQ transactions.
REQ-030 RRESP (OKAY/DECERR) SHALL be forwarded unmodified.

Reset
REQ-031 ap_rst_n low SHALL immediately force IDLE, p=0, g=0, m_axi_ARVALID=0, m_axi_RREADY=0, all s_axi_ARREADY/RVALID=0.
REQ-032 Reset mid-transaction SHALL abandon it without any response; the shared slave is reset by the same ap_rst_n.
REQ-033 Outputs SHALL be valid from the first rising edge after ap_rst_n deasserts.

Verification
REQ-034 Single request: s1 ARADDR=0x08 -> m_axi_ARADDR=0x08 one cycle after grant; RDATA 0xCAFE0001, RRESP=0 delivered only on s1.
REQ-035 Simultaneous s0,s1 requests after reset -> grant order s0,s1,s0,s1 over 4 continuous transactions.
REQ-036 m_axi_ARREADY held low 5 cycles -> m_axi_ARVALID/ARADDR stable, no s_axi_ARREADY pulses.
REQ-037 s_axi_RREADY[g] low 3 cycles during RESP -> m_axi_RREADY low, data held, single handshake.
REQ-038 Slave returns RRESP=3 for ARADDR=0xFC -> RRESP=3 on granted requester.
REQ-039 ap_rst_n asserted in ADDR state -> all outputs 0 asynchronously; next request after release granted by p=0 search.

Source files
------------

// File: rtl/axi_lite_rd_arb_if.sv
// Read-only AXI-lite bundle for the arbiter: N_REQ requester ports on the
// s_axi_* side, one shared slave on the m_axi_* side. The "slave" modport is
// the arbiter's view; "master" is the view of whatever drives the requesters
// and models the shared slave.
interface axi_lite_rd_arb_if #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [N_REQ-1:0]            s_axi_ARVALID;
  logic [N_REQ-1:0]            s_axi_ARREADY;
  logic [N_REQ*ADDR_WIDTH-1:0] s_axi_ARADDR;
  logic [N_REQ-1:0]            s_axi_RVALID;
  logic [N_REQ-1:0]            s_axi_RREADY;
  logic [N_REQ*DATA_WIDTH-1:0] s_axi_RDATA;
  logic [2*N_REQ-1:0]          s_axi_RRESP;

  logic                        m_axi_ARVALID;
  logic                        m_axi_ARREADY;
  logic [ADDR_WIDTH-1:0]       m_axi_ARADDR;
  logic                        m_axi_RVALID;
  logic                        m_axi_RREADY;
  logic [DATA_WIDTH-1:0]       m_axi_RDATA;
  logic [1:0]                  m_axi_RRESP;

  modport slave (
    input  s_axi_ARVALID, s_axi_ARADDR, s_axi_RREADY,
           m_axi_ARREADY, m_axi_RVALID, m_axi_RDATA, m_axi_RRESP,
    output s_axi_ARREADY, s_axi_RVALID, s_axi_RDATA, s_axi_RRESP,
           m_axi_ARVALID, m_axi_ARADDR, m_axi_RREADY
  );

  modport master (
    output s_axi_ARVALID, s_axi_ARADDR, s_axi_RREADY,
           m_axi_ARREADY, m_axi_RVALID, m_axi_RDATA, m_axi_RRESP,
    input  s_axi_ARREADY, s_axi_RVALID, s_axi_RDATA, s_axi_RRESP,
           m_axi_ARVALID, m_axi_ARADDR, m_axi_RREADY
  );
endinterface

// File: rtl/axi_lite_rd_arb.sv
// Round-robin arbiter sharing one AXI-lite read-only slave between N_REQ
// read masters. One transaction in flight: IDLE grants, ADDR issues the
// registered address, RESP passes the read data straight through to the
// granted requester.
module axi_lite_rd_arb #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  axi_lite_rd_arb_if.slave   bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  found;
  logic [IW-1:0]         sel;
  logic [IW:0]           idx;

  // Read data/response are broadcast to every lane; only the granted lane
  // sees RVALID, so the other lanes' copies are don't-care.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign bus.s_axi_RDATA[i*DATA_WIDTH +: DATA_WIDTH] = bus.m_axi_RDATA;
    assign bus.s_axi_RRESP[i*2 +: 2]                   = bus.m_axi_RRESP;
  end

  // Find the first requesting lane at or above the priority pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (!found && bus.s_axi_ARVALID[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    gnt_d             = gnt_q;
    addr_d            = addr_q;
    bus.s_axi_ARREADY = '0;
    bus.s_axi_RVALID  = '0;
    bus.m_axi_ARVALID = 1'b0;
    bus.m_axi_RREADY  = 1'b0;
    bus.m_axi_ARADDR  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          // Gated by reset so no ARREADY leaks out while ap_rst_n is low.
          bus.s_axi_ARREADY[sel] = ap_rst_n;
          gnt_d   = sel;
          addr_d  = bus.s_axi_ARADDR[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus.m_axi_ARVALID = 1'b1;
        if (bus.m_axi_ARREADY) state_d = RESP;
      end
      RESP: begin
        bus.s_axi_RVALID[gnt_q] = bus.m_axi_RVALID;
        bus.m_axi_RREADY        = bus.s_axi_RREADY[gnt_q];
        if (bus.m_axi_RVALID && bus.s_axi_RREADY[gnt_q]) begin
          state_d = IDLE;
          ptr_d   = (gnt_q == IW'(N_REQ-1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_rd_arb.sv
// Directed bench for axi_lite_rd_arb with two requesters. Inputs change on
// the falling edge; outputs are checked 1 ns later.
module tb_axi_lite_rd_arb;
  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 ap_clk = ~ap_clk;

  axi_lite_rd_arb_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_rd_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  task automatic idle_inputs();
    bus.s_axi_ARVALID = '0;
    bus.s_axi_ARADDR  = '0;
    bus.s_axi_RREADY  = '0;
    bus.m_axi_ARREADY = 1'b0;
    bus.m_axi_RVALID  = 1'b0;
    bus.m_axi_RDATA   = '0;
    bus.m_axi_RRESP   = 2'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ap_rst_n = 1'b0;
    bus.s_axi_ARVALID = 2'b11;
    bus.m_axi_RVALID  = 1'b1;
    bus.s_axi_RREADY  = 2'b11;
    repeat (2) @(negedge ap_clk);
    #1;
    vectors++; if (bus.s_axi_ARREADY !== 2'b00) begin miscompares++; $display("FAIL reset_arready: got %b want 00", bus.s_axi_ARREADY); end
    vectors++; if (bus.m_axi_ARVALID !== 1'b0) begin miscompares++; $display("FAIL reset_m_arvalid: got %b want 0", bus.m_axi_ARVALID); end
    vectors++; if (bus.m_axi_RREADY !== 1'b0) begin miscompares++; $display("FAIL reset_m_rready: got %b want 0", bus.m_axi_RREADY); end
    vectors++; if (bus.s_axi_RVALID !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid: got %b want 00", bus.s_axi_RVALID); end
    @(negedge ap_clk);
    idle_inputs();
    ap_rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b10;
    bus.s_axi_ARADDR  = {8'h08, 8'h00};
    #1;
    vectors++; if (bus.s_axi_ARREADY !== 2'b10) begin miscompares++; $display("FAIL single_grant: got %b want 10", bus.s_axi_ARREADY); end
    vectors++; if (bus.m_axi_ARVALID !== 1'b0) begin miscompares++; $display("FAIL single_arvalid_early: got %b want 0", bus.m_axi_ARVALID); end
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b00;
    bus.m_axi_ARREADY = 1'b1;
    #1;
    vectors++; if (bus.m_axi_ARVALID !== 1'b1 || bus.m_axi_ARADDR !== 8'h08) begin miscompares++; $display("FAIL single_araddr: got v=%b a=%h want v=1 a=08", bus.m_axi_ARVALID, bus.m_axi_ARADDR); end
    vectors++; if (bus.s_axi_ARREADY !== 2'b00) begin miscompares++; $display("FAIL single_arready_addr: got %b want 00", bus.s_axi_ARREADY); end
    @(negedge ap_clk);
    bus.m_axi_ARREADY = 1'b0;
    bus.m_axi_RVALID  = 1'b1;
    bus.m_axi_RDATA   = 32'hCAFE0001;
    bus.m_axi_RRESP   = 2'd0;
    bus.s_axi_RREADY  = 2'b11;
    #1;
    vectors++; if (bus.s_axi_RVALID !== 2'b10) begin miscompares++; $display("FAIL single_rvalid: got %b want 10", bus.s_axi_RVALID); end
    vectors++; if (bus.s_axi_RDATA[DW +: DW] !== 32'hCAFE0001) begin miscompares++; $display("FAIL single_rdata: got %h want cafe0001", bus.s_axi_RDATA[DW +: DW]); end
    vectors++; if (bus.s_axi_RRESP[3:2] !== 2'd0) begin miscompares++; $display("FAIL single_rresp: got %0d want 0", bus.s_axi_RRESP[3:2]); end
    vectors++; if (bus.m_axi_RREADY !== 1'b1) begin miscompares++; $display("FAIL single_m_rready: got %b want 1", bus.m_axi_RREADY); end
    @(negedge ap_clk);
    #1;
    vectors++; if (bus.s_axi_RVALID !== 2'b00) begin miscompares++; $display("FAIL single_done: got %b want 00", bus.s_axi_RVALID); end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    logic [7:0] exp_addr;
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    bus.s_axi_ARVALID = 2'b11;
    bus.s_axi_ARADDR  = {8'h20, 8'h10};
    bus.m_axi_ARREADY = 1'b1;
    bus.m_axi_RVALID  = 1'b1;
    bus.m_axi_RDATA   = 32'h0000_5A5A;
    bus.s_axi_RREADY  = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp      = (t % 2 == 1) ? 2'b10 : 2'b01;
      exp_addr = (t % 2 == 1) ? 8'h20 : 8'h10;
      #1;
      vectors++; if (bus.s_axi_ARREADY !== exp) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %b", t, bus.s_axi_ARREADY, exp); end
      @(negedge ap_clk);
      #1;
      vectors++; if (bus.m_axi_ARVALID !== 1'b1 || bus.m_axi_ARADDR !== exp_addr) begin miscompares++; $display("FAIL rr_addr%0d: got v=%b a=%h want v=1 a=%h", t, bus.m_axi_ARVALID, bus.m_axi_ARADDR, exp_addr); end
      @(negedge ap_clk);
      #1;
      vectors++; if (bus.s_axi_RVALID !== exp) begin miscompares++; $display("FAIL rr_rvalid%0d: got %b want %b", t, bus.s_axi_RVALID, exp); end
      @(negedge ap_clk);
    end
    idle_inputs();
  endtask

  task automatic test_ar_stall();
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b01;
    bus.s_axi_ARADDR  = {8'h55, 8'h44};
    #1;
    vectors++; if (bus.s_axi_ARREADY !== 2'b01) begin miscompares++; $display("FAIL stall_grant: got %b want 01", bus.s_axi_ARREADY); end
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if (bus.m_axi_ARVALID !== 1'b1 || bus.m_axi_ARADDR !== 8'h44) begin miscompares++; $display("FAIL stall_hold%0d: got v=%b a=%h want v=1 a=44", i, bus.m_axi_ARVALID, bus.m_axi_ARADDR); end
      vectors++; if (bus.s_axi_ARREADY !== 2'b00) begin miscompares++; $display("FAIL stall_arready%0d: got %b want 00", i, bus.s_axi_ARREADY); end
      @(negedge ap_clk);
    end
    bus.s_axi_ARVALID = 2'b00;
    bus.m_axi_ARREADY = 1'b1;
    @(negedge ap_clk);
    bus.m_axi_ARREADY = 1'b0;
    bus.m_axi_RVALID  = 1'b1;
    bus.s_axi_RREADY  = 2'b11;
    #1;
    vectors++; if (bus.s_axi_RVALID !== 2'b01) begin miscompares++; $display("FAIL stall_rvalid: got %b want 01", bus.s_axi_RVALID); end
    @(negedge ap_clk);
    idle_inputs();
  endtask

  task automatic test_r_stall();
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b10;
    bus.s_axi_ARADDR  = {8'h0C, 8'h00};
    bus.m_axi_ARREADY = 1'b1;
    #1;
    vectors++; if (bus.s_axi_ARREADY !== 2'b10) begin miscompares++; $display("FAIL rstall_grant: got %b want 10", bus.s_axi_ARREADY); end
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b00;
    #1;
    vectors++; if (bus.m_axi_ARADDR !== 8'h0C) begin miscompares++; $display("FAIL rstall_araddr: got %h want 0c", bus.m_axi_ARADDR); end
    @(negedge ap_clk);
    bus.m_axi_ARREADY = 1'b0;
    bus.m_axi_RVALID  = 1'b1;
    bus.m_axi_RDATA   = 32'h12345678;
    bus.s_axi_RREADY  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (bus.m_axi_RREADY !== 1'b0) begin miscompares++; $display("FAIL rstall_m_rready%0d: got %b want 0", i, bus.m_axi_RREADY); end
      vectors++; if (bus.s_axi_RVALID !== 2'b10 || bus.s_axi_RDATA[DW +: DW] !== 32'h12345678) begin miscompares++; $display("FAIL rstall_hold%0d: got v=%b d=%h want v=10 d=12345678", i, bus.s_axi_RVALID, bus.s_axi_RDATA[DW +: DW]); end
      @(negedge ap_clk);
    end
    bus.s_axi_RREADY = 2'b10;
    #1;
    vectors++; if (bus.m_axi_RREADY !== 1'b1) begin miscompares++; $display("FAIL rstall_release: got %b want 1", bus.m_axi_RREADY); end
    @(negedge ap_clk);
    #1;
    vectors++; if (bus.s_axi_RVALID !== 2'b00 || bus.m_axi_RREADY !== 1'b0) begin miscompares++; $display("FAIL rstall_single: got v=%b r=%b want v=00 r=0", bus.s_axi_RVALID, bus.m_axi_RREADY); end
    idle_inputs();
  endtask

  task automatic test_decerr();
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b01;
    bus.s_axi_ARADDR  = {8'h00, 8'hFC};
    bus.m_axi_ARREADY = 1'b1;
    #1;
    vectors++; if (bus.s_axi_ARREADY !== 2'b01) begin miscompares++; $display("FAIL decerr_grant: got %b want 01", bus.s_axi_ARREADY); end
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b00;
    #1;
    vectors++; if (bus.m_axi_ARADDR !== 8'hFC) begin miscompares++; $display("FAIL decerr_araddr: got %h want fc", bus.m_axi_ARADDR); end
    @(negedge ap_clk);
    bus.m_axi_ARREADY = 1'b0;
    bus.m_axi_RVALID  = 1'b1;
    bus.m_axi_RDATA   = 32'hDEADBEEF;
    bus.m_axi_RRESP   = 2'd3;
    bus.s_axi_RREADY  = 2'b01;
    #1;
    vectors++; if (bus.s_axi_RVALID !== 2'b01 || bus.s_axi_RRESP[1:0] !== 2'd3) begin miscompares++; $display("FAIL decerr_rresp: got v=%b resp=%0d want v=01 resp=3", bus.s_axi_RVALID, bus.s_axi_RRESP[1:0]); end
    @(negedge ap_clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b10;
    bus.s_axi_ARADDR  = {8'h30, 8'h31};
    #1;
    vectors++; if (bus.s_axi_ARREADY !== 2'b10) begin miscompares++; $display("FAIL rstmid_grant: got %b want 10", bus.s_axi_ARREADY); end
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b00;
    #1;
    vectors++; if (bus.m_axi_ARVALID !== 1'b1) begin miscompares++; $display("FAIL rstmid_addr_state: got %b want 1", bus.m_axi_ARVALID); end
    #1;
    ap_rst_n = 1'b0;
    #1;
    vectors++; if (bus.m_axi_ARVALID !== 1'b0 || bus.s_axi_ARREADY !== 2'b00 || bus.m_axi_RREADY !== 1'b0 || bus.s_axi_RVALID !== 2'b00) begin miscompares++; $display("FAIL rstmid_async: got arv=%b ard=%b rr=%b rv=%b want all 0", bus.m_axi_ARVALID, bus.s_axi_ARREADY, bus.m_axi_RREADY, bus.s_axi_RVALID); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    bus.s_axi_ARVALID = 2'b11;
    #1;
    vectors++; if (bus.s_axi_ARREADY !== 2'b01) begin miscompares++; $display("FAIL rstmid_ptr0: got %b want 01", bus.s_axi_ARREADY); end
    @(negedge ap_clk);
    bus.s_axi_ARVALID = 2'b00;
    #1;
    vectors++; if (bus.m_axi_ARADDR !== 8'h31) begin miscompares++; $display("FAIL rstmid_araddr: got %h want 31", bus.m_axi_ARADDR); end
    bus.m_axi_ARREADY = 1'b1;
    @(negedge ap_clk);
    bus.m_axi_ARREADY = 1'b0;
    bus.m_axi_RVALID  = 1'b1;
    bus.s_axi_RREADY  = 2'b11;
    @(negedge ap_clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ar_stall();
    test_r_stall();
    test_decerr();
    test_reset_mid();
    repeat (2) @(negedge ap_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
